// File: rtl/arbiter_rr_n_reg.sv
// arbiter_rr_n_reg: N-way round-robin arbiter with a registered output stage (one cycle latency).
// Define ARB_LAST_PRIORITY_EN to give requester N-1 absolute priority over the round-robin engines.
module arbiter_rr_n_reg #(
   parameter  int unsigned N      = 5,
   parameter  int unsigned DWIDTH = 11,
   localparam int unsigned IDX_W  = $clog2(N)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N-1:0]        in_valid,
   input  logic [N*DWIDTH-1:0] in_data,
   output logic [N-1:0]        in_ready,
   output logic                out_valid,
   output logic [DWIDTH-1:0]   out_data,
   output logic [IDX_W-1:0]    out_id,
   input  logic                out_ready
);

`ifdef ARB_LAST_PRIORITY_EN
   localparam int unsigned SCAN_N = N - 1;
`else
   localparam int unsigned SCAN_N = N;
`endif

   logic [IDX_W-1:0]  ptr;
   logic [IDX_W-1:0]  win;
   logic              found;
   logic              hold_ptr;
   logic              can_load;
   logic [DWIDTH-1:0] slot [N];
   int unsigned       scan_base;
   int unsigned       cand;

   always_comb begin
      for (int unsigned k = 0; k < N; k++) begin
         slot[k] = in_data[k*DWIDTH +: DWIDTH];
      end
   end

   // ptr can point at N-1 when that index is excluded from the scan; restart at 0 then.
   always_comb begin
      found     = 1'b0;
      win       = '0;
      hold_ptr  = 1'b0;
      cand      = '0;
      scan_base = (32'(ptr) >= SCAN_N) ? '0 : 32'(ptr);
      for (int unsigned k = 0; k < SCAN_N; k++) begin
         cand = scan_base + k;
         if (cand >= SCAN_N) begin
            cand = cand - SCAN_N;
         end
         if (!found && in_valid[cand[IDX_W-1:0]]) begin
            found = 1'b1;
            win   = cand[IDX_W-1:0];
         end
      end
`ifdef ARB_LAST_PRIORITY_EN
      if (in_valid[N-1]) begin
         win      = IDX_W'(N - 1);
         hold_ptr = 1'b1;
      end
`endif
   end

   always_comb begin
      can_load = (|in_valid) && (!out_valid || out_ready) && !rst;
      in_ready = can_load ? (N'(1) << win) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
         ptr       <= '0;
      end else if (can_load) begin
         out_valid <= 1'b1;
         out_data  <= slot[win];
         out_id    <= win;
         if (!hold_ptr) begin
            ptr <= (win == IDX_W'(N - 1)) ? '0 : win + 1'b1;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
